sha_msg_padder: RTL

- Upstream feeder for the SHA core.
- Accepts a message as a 32-bit big-endian word stream with valid/ready, and applies FIPS 180-4 padding: 0x80 marker, zero fill, then the message bit length.
- Assembles 512-bit (SHA-256) or 1024-bit (SHA-384/512) blocks and issues them to the core on a start/input_valid pulse.
- Waits for the core's output_valid before issuing the next block, and signals msg_done after the final block completes.

---
 rtl/sha_pad_pkg.sv | 64 ++++++
 rtl/sha_blk_buf.sv | 43 ++++
 rtl/sha_msg_padder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha_pad_pkg.sv
// sha_pad_pkg: shared types and helpers for the SHA message padder.
//   - pad_state_e : padder FSM state encoding
//   - next_blk_e  : what the padder does once the core finishes the current block
//   - NW/LP constants for SHA-256 (512-bit block) and SHA-384/512 (1024-bit block)
//   - PAD_MARK and the final-word masking helpers
package sha_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PADW,
    ST_ZERO,
    ST_LENW,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } pad_state_e;

  // Follow-up action after the core acknowledges a block.
  typedef enum logic [1:0] {
    NX_FILL,  // message continues into the next block
    NX_MARK,  // message ended on the last word; marker opens the next block
    NX_LEN,   // marker placed but no room for the length; length-only block
    NX_DONE   // block carried the length field; message finished
  } next_blk_e;

  localparam logic [31:0] PAD_MARK = 32'h8000_0000;

  localparam logic [5:0] NW_256 = 6'd16;
  localparam logic [5:0] NW_512 = 6'd32;
  localparam logic [5:0] LP_256 = 6'd14;
  localparam logic [5:0] LP_512 = 6'd28;

  // Words per block for the selected mode (wide = hash_size[1]).
  function automatic logic [5:0] nw_of(input logic wide);
    return wide ? NW_512 : NW_256;
  endfunction

  // First word of the length field for the selected mode.
  function automatic logic [5:0] lp_of(input logic wide);
    return wide ? LP_512 : LP_256;
  endfunction

  // Mask of the valid message bytes in a final word (nb = valid bytes - 1).
  function automatic logic [31:0] byte_mask(input logic [1:0] nb);
    logic [31:0] m;
    case (nb)
      2'd0:    m = 32'hFF00_0000;
      2'd1:    m = 32'hFFFF_0000;
      2'd2:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Final word with the unused bytes cleared and the 0x80 marker placed in
  // the byte right after the last valid one (only meaningful for nb < 3).
  function automatic logic [31:0] tail_word(input logic [31:0] d, input logic [1:0] nb);
    logic [5:0] sh;
    sh = 6'({nb, 3'b000}) + 6'd8;
    return (d & byte_mask(nb)) | (PAD_MARK >> sh);
  endfunction

endpackage

// File: rtl/sha_blk_buf.sv
// sha_blk_buf: 32 x 32-bit block buffer feeding the SHA core.
//   clk, rst  : clock, asynchronous active-low reset (buffer cleared)
//   clr       : synchronous clear of every word
//   we/waddr/wdata : single-word write; a write wins over clr for its word,
//               so a block can be cleared and its first word stored together
//   rdata     : flattened block, word 0 at [1023:992]
module sha_blk_buf (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [31:0]   wdata,
  output logic [1023:0] rdata
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      mem_d[i] = mem_q[i];
      if (clr) mem_d[i] = '0;
      if (we && (waddr == 5'(i))) mem_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 32; i++) begin
      rdata[1023-32*i -: 32] = mem_q[i];
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// sha_msg_padder: FIPS 180-4 message padder in front of the SHA core.
//   clk, rst            : clock, asynchronous active-low reset
//   hash_size           : mode, bit1 selects 1024-bit blocks (SHA-384/512)
//   msg_empty           : request a zero-length message while idle
//   s_data/s_valid/s_last/s_bytes/s_ready : 32-bit big-endian message stream
//   sha_start           : pulse issuing the first block of a message
//   sha_input_valid     : pulse issuing each later block
//   sha_win             : current block, word 0 at [1023:992]
//   sha_hash_size       : mode latched at message start
//   sha_output_valid    : core finished the issued block
//   busy, msg_done      : message in progress / final block hashed
//   len_err             : bit count overflowed LEN_W during this message
//
// Handshake: a word transfers on a rising clk edge where s_valid and s_ready
// are both high; s_ready depends only on internal state, never on s_valid.
module sha_msg_padder
  import sha_pad_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    hash_size,
  input  logic          msg_empty,
  input  logic [31:0]   s_data,
  input  logic          s_valid,
  input  logic          s_last,
  input  logic [1:0]    s_bytes,
  output logic          s_ready,
  output logic          sha_start,
  output logic          sha_input_valid,
  output logic [1023:0] sha_win,
  output logic [1:0]    sha_hash_size,
  input  logic          sha_output_valid,
  output logic          busy,
  output logic          msg_done,
  output logic          len_err
);

  pad_state_e       state_q, state_d;
  next_blk_e        nx_q, nx_d;
  logic [4:0]       widx_q, widx_d;
  logic [LEN_W-1:0] bitlen_q, bitlen_d;
  logic             len_err_q, len_err_d;
  logic [1:0]       hs_q, hs_d;
  logic             first_q, first_d;
  // Holds s_ready low for the first cycle after reset release.
  logic             run_q;

  logic             buf_clr, buf_we;
  logic [4:0]       buf_waddr;
  logic [31:0]      buf_wdata;

  logic             in_idle, wide, acc;
  logic [5:0]       nw, lp, next_pos, lw_sel;
  logic [4:0]       cur_idx;
  logic [LEN_W-1:0] base_len;
  logic [LEN_W:0]   inc, len_sum;
  logic [127:0]     len128;
  logic [31:0]      len_word;

  sha_blk_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (buf_clr),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .rdata (sha_win)
  );

  // Datapath helpers. In IDLE the incoming word starts a fresh message, so
  // mode, index and length come from the inputs / zero rather than the flops.
  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    wide     = in_idle ? hash_size[1] : hs_q[1];
    nw       = nw_of(wide);
    lp       = lp_of(wide);
    cur_idx  = in_idle ? 5'd0 : widx_q;
    base_len = in_idle ? '0 : bitlen_q;
    if (s_last && (s_bytes != 2'd3)) inc = (LEN_W+1)'({s_bytes, 3'b000} + 5'd8);
    else                             inc = (LEN_W+1)'(32);
    len_sum  = {1'b0, base_len} + inc;
    // Length field is MSB-first; lw_sel counts words from the least
    // significant end, so bits above LEN_W come out as zero.
    len128   = 128'(bitlen_q);
    lw_sel   = nw - 6'd1 - {1'b0, widx_q};
    len_word = 32'(len128 >> {lw_sel, 5'b00000});
    next_pos = {1'b0, widx_q} + 6'd1;
    s_ready  = (in_idle && run_q) ||
               ((state_q == ST_FILL) && ({1'b0, widx_q} < nw));
    acc      = s_valid && s_ready;
  end

  always_comb begin
    state_d         = state_q;
    nx_d            = nx_q;
    widx_d          = widx_q;
    bitlen_d        = bitlen_q;
    len_err_d       = len_err_q;
    hs_d            = hs_q;
    first_d         = first_q;
    buf_clr         = 1'b0;
    buf_we          = 1'b0;
    buf_waddr       = widx_q;
    buf_wdata       = '0;
    sha_start       = 1'b0;
    sha_input_valid = 1'b0;
    msg_done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && run_q) begin
          // Word itself is handled by the accept path below.
          buf_clr   = 1'b1;
          hs_d      = hash_size;
          first_d   = 1'b1;
          len_err_d = 1'b0;
        end else if (msg_empty && run_q) begin
          buf_clr   = 1'b1;
          hs_d      = hash_size;
          first_d   = 1'b1;
          len_err_d = 1'b0;
          bitlen_d  = '0;
          widx_d    = '0;
          state_d   = ST_PADW;
        end
      end
      ST_PADW: begin
        buf_we    = 1'b1;
        buf_wdata = PAD_MARK;
        state_d   = ST_ZERO;
      end
      ST_ZERO: begin
        // widx points at the word holding the marker.
        if (next_pos <= lp) begin
          widx_d  = lp[4:0];
          state_d = ST_LENW;
        end else begin
          nx_d    = NX_LEN;
          state_d = ST_ISSUE;
        end
      end
      ST_LENW: begin
        buf_we    = 1'b1;
        buf_wdata = len_word;
        if ({1'b0, widx_q} == nw - 6'd1) begin
          nx_d    = NX_DONE;
          state_d = ST_ISSUE;
        end else begin
          widx_d  = widx_q + 5'd1;
        end
      end
      ST_ISSUE: begin
        sha_start       = first_q;
        sha_input_valid = !first_q;
        first_d         = 1'b0;
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        if (sha_output_valid) begin
          buf_clr = 1'b1;
          case (nx_q)
            NX_FILL: begin widx_d = '0;       state_d = ST_FILL; end
            NX_MARK: begin widx_d = '0;       state_d = ST_PADW; end
            NX_LEN:  begin widx_d = lp[4:0];  state_d = ST_LENW; end
            default: begin                    state_d = ST_DONE; end
          endcase
        end
      end
      ST_DONE: begin
        msg_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: ;  // ST_FILL: words handled by the accept path
    endcase

    if (acc) begin
      bitlen_d  = len_sum[LEN_W-1:0];
      len_err_d = len_err_d | len_sum[LEN_W];
      buf_we    = 1'b1;
      buf_waddr = cur_idx;
      buf_wdata = s_data;
      if (s_last && (s_bytes != 2'd3)) begin
        buf_wdata = tail_word(s_data, s_bytes);
        widx_d    = cur_idx;
        state_d   = ST_ZERO;
      end else if (s_last) begin
        if ({1'b0, cur_idx} == nw - 6'd1) begin
          // Block is full: marker and length go into an extra block.
          nx_d    = NX_MARK;
          state_d = ST_ISSUE;
        end else begin
          widx_d  = cur_idx + 5'd1;
          state_d = ST_PADW;
        end
      end else if ({1'b0, cur_idx} == nw - 6'd1) begin
        nx_d    = NX_FILL;
        state_d = ST_ISSUE;
      end else begin
        widx_d  = cur_idx + 5'd1;
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      nx_q      <= NX_FILL;
      widx_q    <= '0;
      bitlen_q  <= '0;
      len_err_q <= 1'b0;
      hs_q      <= '0;
      first_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nx_q      <= nx_d;
      widx_q    <= widx_d;
      bitlen_q  <= bitlen_d;
      len_err_q <= len_err_d;
      hs_q      <= hs_d;
      first_q   <= first_d;
      run_q     <= 1'b1;
    end
  end

  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign sha_hash_size = hs_q;
  assign len_err       = len_err_q;

endmodule
